// File: rtl/alu_pkg.sv
// Shared opcode, width and issue-FSM definitions for the ALU issue path.
package alu_pkg;

  localparam int ALU_OPW = 3;

  localparam logic [ALU_OPW-1:0] U_ADD = 3'b000;
  localparam logic [ALU_OPW-1:0] S_ADD = 3'b001;
  localparam logic [ALU_OPW-1:0] U_SUB = 3'b010;
  localparam logic [ALU_OPW-1:0] S_SUB = 3'b011;
  localparam logic [ALU_OPW-1:0] AND   = 3'b100;
  localparam logic [ALU_OPW-1:0] OR    = 3'b101;
  localparam logic [ALU_OPW-1:0] XOR   = 3'b110;
  localparam logic [ALU_OPW-1:0] DIV2  = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } issue_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// Request FIFO for the ALU issue queue: storage, wrapping pointers, occupancy.
module alu_issue_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_wdata,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_full;
  logic             w_empty;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n && !i_flush) begin
      assert (!(i_push && w_full && !i_pop));
      assert (!(i_pop && w_empty));
    end
  end

  assign o_rdata = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/alu_issue_queue.sv
// Buffers ALU requests and issues one per cycle onto registered ALU inputs.
// Optional synchronous flush port when ALU_ISSUE_FLUSH_EN is defined.
module alu_issue_queue
  import alu_pkg::*;
#(
  parameter int NBITS = 4,
  parameter int DEPTH = 4
) (
`ifdef ALU_ISSUE_FLUSH_EN
  input  logic                   flush,
`endif
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NBITS-1:0]       in_a,
  input  logic [NBITS-1:0]       in_b,
  input  logic [ALU_OPW-1:0]     in_opcode,
  input  logic                   issue_en,
  output logic [NBITS-1:0]       alu_a,
  output logic [NBITS-1:0]       alu_b,
  output logic [ALU_OPW-1:0]     alu_opcode,
  output logic                   alu_valid,
  output logic                   res_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int W  = 2*NBITS + ALU_OPW;
  localparam int CW = $clog2(DEPTH) + 1;

  logic             w_flush;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [W-1:0]     w_head;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_cnt_nxt;

  logic [NBITS-1:0]   r_a;
  logic [NBITS-1:0]   r_b;
  logic [ALU_OPW-1:0] r_op;
  logic               r_valid;
  logic               r_res_valid;
  issue_state_e       r_state;
  issue_state_e       w_state_nxt;

`ifdef ALU_ISSUE_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_pop     = !w_empty && issue_en && !w_flush;
  assign in_ready  = (!w_full || w_pop) && !w_flush;
  assign w_push    = in_valid && in_ready;
  assign w_cnt_nxt = w_flush ? '0 : w_count + CW'(w_push) - CW'(w_pop);

  alu_issue_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata ({in_opcode, in_a, in_b}),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: if (w_cnt_nxt != '0) w_state_nxt = RUN;
      RUN: begin
        if (!issue_en && !w_empty)  w_state_nxt = HOLD;
        else if (w_cnt_nxt == '0)   w_state_nxt = IDLE;
      end
      HOLD: if (issue_en) w_state_nxt = (w_cnt_nxt == '0) ? IDLE : RUN;
      default: w_state_nxt = IDLE;
    endcase
    if (w_flush) w_state_nxt = IDLE;
  end

  // Operands hold across non-issue cycles; only alu_valid marks new work.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_valid     <= 1'b0;
      r_res_valid <= 1'b0;
    end else begin
      if (w_pop) {r_op, r_a, r_b} <= w_head;
      r_valid     <= w_pop;
      r_res_valid <= r_valid;
    end
  end

  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_opcode = r_op;
  assign alu_valid  = r_valid;
  assign res_valid  = r_res_valid;
  assign count      = w_count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed self-checking bench for alu_issue_queue with a reference queue model.
module tb_alu_issue_queue;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [2:0] in_opcode;
  logic       issue_en;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [2:0] alu_opcode;
  logic       alu_valid;
  logic       res_valid;
  logic [2:0] count;
`ifdef ALU_ISSUE_FLUSH_EN
  logic       flush;
`endif

  int errors = 0;
  int checks = 0;

  logic [10:0] q[$];
  logic [10:0] last_iss;
  logic        pp;

  alu_issue_queue #(.NBITS(4), .DEPTH(4)) dut (
`ifdef ALU_ISSUE_FLUSH_EN
    .flush      (flush),
`endif
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_opcode  (in_opcode),
    .issue_en   (issue_en),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_valid  (alu_valid),
    .res_valid  (res_valid),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [3:0] alu_fn(input logic [2:0] op,
                                        input logic [3:0] a,
                                        input logic [3:0] b);
    logic [3:0] r;
    case (op)
      3'd0, 3'd1: r = a + b;
      3'd2, 3'd3: r = a - b;
      3'd4:       r = a & b;
      3'd5:       r = a | b;
      3'd6:       r = a ^ b;
      default:    r = a >> 1;
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_iss = '0;
    pp = 1'b0;
  endtask

  // One cycle: drive, check in_ready, clock, check issue/hold/count/res_valid.
  task automatic step(input logic v, input logic [3:0] a,
                      input logic [3:0] b, input logic [2:0] op,
                      input logic ien);
    logic pop_e;
    logic rdy_e;
    logic res_e;
    logic [10:0] it;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_opcode = op;
    issue_en  = ien;
    #1;
    pop_e = (q.size() > 0) && ien;
    rdy_e = (q.size() < 4) || pop_e;
    res_e = pp;
    chk("in_ready", 32'(in_ready), 32'(rdy_e));
    it = last_iss;
    if (pop_e) it = q.pop_front();
    if (v && rdy_e) q.push_back({op, a, b});
    @(posedge clk);
    #1;
    chk("alu_valid", 32'(alu_valid), 32'(pop_e));
    chk(pop_e ? "alu_issue" : "alu_held",
        32'({alu_opcode, alu_a, alu_b}), 32'(it));
    chk("count", 32'(count), 32'(q.size()));
    chk("res_valid", 32'(res_valid), 32'(res_e));
    last_iss = it;
    pp = pop_e;
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_opcode = '0;
    issue_en = 1'b0;
`ifdef ALU_ISSUE_FLUSH_EN
    flush = 1'b0;
`endif
    model_reset();
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Single request: 3 + 4
    step(1'b1, 4'd3, 4'd4, 3'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    chk("issue_a", 32'(alu_a), 32'd3);
    chk("issue_b", 32'(alu_b), 32'd4);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    chk("alu_result", 32'(alu_fn(alu_opcode, alu_a, alu_b)), 32'd7);

    // Fill with issue blocked, fifth is refused until issue opens
    for (int i = 0; i < 5; i++)
      step(1'b1, 4'(i + 1), 4'(i + 5), 3'(i), 1'b0);
    chk("full_count", 32'(count), 32'd4);
    chk("full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 4'd5, 4'd9, 3'd4, 1'b1);
    chk("first_out_a", 32'(alu_a), 32'd1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);

    // Full queue streaming: push and pop every cycle
    for (int i = 0; i < 4; i++)
      step(1'b1, 4'(i * 3), 4'(15 - i), 3'(i + 2), 1'b0);
    for (int i = 0; i < 8; i++)
      step(1'b1, 4'(i * 5 + 1), 4'(i * 7 + 2), 3'(i), 1'b1);
    for (int i = 0; i < 5; i++)
      step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);

    // Reset mid-operation with count 3 and alu_valid high
    for (int i = 0; i < 3; i++)
      step(1'b1, 4'(i + 10), 4'(i + 2), 3'd6, 1'b0);
    step(1'b1, 4'd13, 4'd5, 3'd7, 1'b1);
    chk("pre_rst_count", 32'(count), 32'd3);
    reset = 1'b0;
    #1;
    chk("mid_rst_alu_valid", 32'(alu_valid), 32'd0);
    chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    model_reset();
    in_valid = 1'b0;
    issue_en = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_count", 32'(count), 32'd0);

    // RUN, HOLD, RUN, IDLE with two queued; DIV2 still forwards B
    step(1'b1, 4'd9, 4'd2, 3'd7, 1'b0);
    step(1'b1, 4'd6, 4'd11, 3'd5, 1'b0);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    chk("div2_b_fwd", 32'(alu_b), 32'd2);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b0);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    chk("or_result", 32'(alu_fn(alu_opcode, alu_a, alu_b)), 32'hf);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);

`ifdef ALU_ISSUE_FLUSH_EN
    step(1'b1, 4'd1, 4'd1, 3'd0, 1'b0);
    step(1'b1, 4'd2, 4'd2, 3'd0, 1'b0);
    in_valid = 1'b1;
    in_a = 4'd15;
    in_b = 4'd15;
    issue_en = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    model_reset();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_alu_valid", 32'(alu_valid), 32'd0);
    step(1'b0, 4'd0, 4'd0, 3'd0, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
